// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types and GF(2^8) helpers for the MixColumns engine.
//   aes_col_t   : one 32-bit state column, row 0 in bits [31:24]
//   aes_fsm_e   : engine control states (IDLE / RUN / DONE)
//   AES_POLY    : low byte of the AES field polynomial x^8+x^4+x^3+x+1
//   xtime()     : multiply a field element by {02}
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef logic [31:0] aes_col_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } aes_fsm_e;

    localparam logic [7:0] AES_POLY = 8'h1B;

    // Shift left by one; fold the dropped bit 7 back in with the polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_mixcolumn_lane.sv
// ---------------------------------------------------------------------------
// aes_mixcolumn_lane
// Combinational MixColumns / InvMixColumns of a single 32-bit column.
//   col_in  : input column, row 0 in bits [31:24]
//   inverse : 1 selects InvMixColumns (only with AES_INV_MIXCOL_EN)
//   col_out : transformed column, same byte layout
// Build option: AES_INV_MIXCOL_EN compiles the inverse datapath; without it
// the inverse select is ignored and only the forward matrix exists.
// ---------------------------------------------------------------------------
module aes_mixcolumn_lane
    import aes_pkg::*;
(
    input  aes_col_t col_in,
    input  logic     inverse,
    output aes_col_t col_out
);

    logic [7:0] a   [4];   // column bytes, a[0] = row 0
    logic [7:0] x2  [4];   // {02}*a
    logic [7:0] fwd [4];   // forward result per row

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row
            assign a[gi]  = col_in[31-8*gi -: 8];
            assign x2[gi] = xtime(a[gi]);
            // Row r of {02 03 01 01} rotated right by r; {03}*b = {02}*b ^ b.
            assign fwd[gi] = x2[gi]
                           ^ x2[(gi+1)%4] ^ a[(gi+1)%4]
                           ^ a[(gi+2)%4]
                           ^ a[(gi+3)%4];
        end
    endgenerate

`ifdef AES_INV_MIXCOL_EN
    logic [7:0] x4  [4];   // {04}*a
    logic [7:0] x8  [4];   // {08}*a
    logic [7:0] inv [4];   // inverse result per row

    generate
        for (gi = 0; gi < 4; gi++) begin : g_inv_row
            assign x4[gi] = xtime(x2[gi]);
            assign x8[gi] = xtime(x4[gi]);
            // {0E}=8+4+2, {0B}=8+2+1, {0D}=8+4+1, {09}=8+1
            assign inv[gi] = (x8[gi]       ^ x4[gi]       ^ x2[gi])
                           ^ (x8[(gi+1)%4] ^ x2[(gi+1)%4] ^ a[(gi+1)%4])
                           ^ (x8[(gi+2)%4] ^ x4[(gi+2)%4] ^ a[(gi+2)%4])
                           ^ (x8[(gi+3)%4] ^ a[(gi+3)%4]);
        end
    endgenerate

    assign col_out = inverse ? {inv[0], inv[1], inv[2], inv[3]}
                             : {fwd[0], fwd[1], fwd[2], fwd[3]};
`else
    logic unused_inverse;
    assign unused_inverse = inverse;
    assign col_out = {fwd[0], fwd[1], fwd[2], fwd[3]};
`endif

endmodule

// File: rtl/aes_mixcolumns_engine.sv
// ---------------------------------------------------------------------------
// aes_mixcolumns_engine
// Applies AES MixColumns (or InvMixColumns) to a 128-bit state, NUM_LANES
// columns per cycle, with a valid/ready handshake on both sides.
//   clk, rst_n      : clock, asynchronous active-low reset
//   flush           : synchronous abort; returns to IDLE next cycle
//   in_valid/ready  : input handshake; in_ready only in IDLE
//   in_inverse      : 1 = InvMixColumns (needs AES_INV_MIXCOL_EN)
//   in_state        : column c at [127-32c -: 32], row 0 is the top byte
//   out_valid/ready : output handshake; result held in DONE until taken
//   out_state       : result, same layout; holds the last completed block
//   busy            : engine not in IDLE
// Parameter NUM_LANES (1, 2 or 4): columns transformed per cycle; a block
// takes BEATS = 4/NUM_LANES cycles.
// Build option: AES_INV_MIXCOL_EN enables inverse support.
// ---------------------------------------------------------------------------
module aes_mixcolumns_engine
    import aes_pkg::*;
#(
    parameter int NUM_LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inverse,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int         BEATS     = 4 / NUM_LANES;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    aes_fsm_e     state_reg, state_next;
    logic [1:0]   beat_reg, beat_next;
    aes_col_t     work_reg  [4];
    aes_col_t     work_next [4];
    logic [127:0] out_state_reg, out_state_next;
    // Low through reset and until the first edge after release, so in_ready
    // cannot rise before the engine has seen a clock.
    logic         ready_en_reg;
    logic         lane_inverse;

`ifdef AES_INV_MIXCOL_EN
    logic inverse_reg, inverse_next;
    assign lane_inverse = inverse_reg;
`else
    logic unused_in_inverse;
    assign unused_in_inverse = in_inverse;
    assign lane_inverse      = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Lane datapath: lane gi works on column beat*NUM_LANES+gi.
    // ---------------------------------------------------------------------
    logic [1:0] lane_idx [NUM_LANES];
    aes_col_t   lane_in  [NUM_LANES];
    aes_col_t   lane_out [NUM_LANES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign lane_idx[gi] = 2'((32'(beat_reg) * NUM_LANES) + gi);
            assign lane_in[gi]  = work_reg[lane_idx[gi]];

            aes_mixcolumn_lane u_lane (
                .col_in  (lane_in[gi]),
                .inverse (lane_inverse),
                .col_out (lane_out[gi])
            );
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Next-state / datapath logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        beat_next      = beat_reg;
        out_state_next = out_state_reg;
        for (int c = 0; c < 4; c++) begin
            work_next[c] = work_reg[c];
        end
`ifdef AES_INV_MIXCOL_EN
        inverse_next = inverse_reg;
`endif

        if (flush) begin
            state_next = ST_IDLE;
            beat_next  = 2'd0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (in_valid && ready_en_reg) begin
                        for (int c = 0; c < 4; c++) begin
                            work_next[c] = in_state[127-32*c -: 32];
                        end
`ifdef AES_INV_MIXCOL_EN
                        inverse_next = in_inverse;
`endif
                        beat_next  = 2'd0;
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int l = 0; l < NUM_LANES; l++) begin
                        work_next[lane_idx[l]] = lane_out[l];
                    end
                    beat_next = beat_reg + 2'd1;
                    if (beat_reg == LAST_BEAT) begin
                        // Publish the finished block only here, so out_state
                        // keeps the previous result while the next one runs.
                        out_state_next = {work_next[0], work_next[1],
                                          work_next[2], work_next[3]};
                        beat_next      = 2'd0;
                        state_next     = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    beat_next  = 2'd0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            beat_reg      <= 2'd0;
            out_state_reg <= '0;
            ready_en_reg  <= 1'b0;
            for (int c = 0; c < 4; c++) begin
                work_reg[c] <= '0;
            end
`ifdef AES_INV_MIXCOL_EN
            inverse_reg   <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            beat_reg      <= beat_next;
            out_state_reg <= out_state_next;
            ready_en_reg  <= 1'b1;
            for (int c = 0; c < 4; c++) begin
                work_reg[c] <= work_next[c];
            end
`ifdef AES_INV_MIXCOL_EN
            inverse_reg   <= inverse_next;
`endif
        end
    end

    assign in_ready  = (state_reg == ST_IDLE) && ready_en_reg;
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg != ST_IDLE);
    assign out_state = out_state_reg;

endmodule

// File: tb/tb_aes_mixcolumns_engine.sv
// ---------------------------------------------------------------------------
// tb_aes_mixcolumns_engine
// Directed bench driving a 4-lane and a 1-lane engine side by side with
// hand-computed MixColumns vectors.
// ---------------------------------------------------------------------------
module tb_aes_mixcolumns_engine;

    localparam logic [127:0] VEC     = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] EXP     = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
`ifdef AES_INV_MIXCOL_EN
    localparam logic [127:0] INV_EXP = VEC;
`else
    localparam logic [127:0] INV_EXP = 128'hcd504506_9f494f1f_01010101_c6c6c6c6;
`endif
    localparam logic [127:0] D4_VEC  = {4{32'hd4d4d4d5}};
    localparam logic [127:0] D4_EXP  = {4{32'hd5d5d7d6}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_inverse;
    logic [127:0] in_state;

    logic         in_valid_4, in_ready_4, out_valid_4, out_ready_4, busy_4;
    logic [127:0] out_state_4;
    logic         in_valid_1, in_ready_1, out_valid_1, out_ready_1, busy_1;
    logic [127:0] out_state_1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_mixcolumns_engine #(.NUM_LANES(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid_4),
        .in_ready   (in_ready_4),
        .in_inverse (in_inverse),
        .in_state   (in_state),
        .out_valid  (out_valid_4),
        .out_ready  (out_ready_4),
        .out_state  (out_state_4),
        .busy       (busy_4)
    );

    aes_mixcolumns_engine #(.NUM_LANES(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid_1),
        .in_ready   (in_ready_1),
        .in_inverse (in_inverse),
        .in_state   (in_state),
        .out_valid  (out_valid_1),
        .out_ready  (out_ready_1),
        .out_state  (out_state_1),
        .busy       (busy_1)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_inverse = 1'b0; in_state = '0;
        in_valid_4 = 1'b0; out_ready_4 = 1'b0;
        in_valid_1 = 1'b0; out_ready_1 = 1'b1;

        // Reset values, before any clock edge
        #2;
        check("rst_in_ready4",  in_ready_4,  0);
        check("rst_out_valid4", out_valid_4, 0);
        check("rst_busy4",      busy_4,      0);
        check("rst_out_state4", out_state_4, 0);
        check("rst_out_state1", out_state_1, 0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rel_in_ready_no_edge", in_ready_4, 0);
        step();
        check("rel_in_ready4_first_edge", in_ready_4, 1);
        check("rel_in_ready1_first_edge", in_ready_1, 1);
        $display("txn reset release: in_ready4=%0b in_ready1=%0b", in_ready_4, in_ready_1);

        // Forward block on both engines; 4-lane consumer stalls 5 cycles
        in_state = VEC; in_inverse = 1'b0;
        in_valid_4 = 1'b1; in_valid_1 = 1'b1;
        step();
        in_valid_4 = 1'b0; in_valid_1 = 1'b0;
        in_state = '1;   // must be ignored while not IDLE
        check("fwd4_valid_accept_edge", out_valid_4, 0);
        check("fwd4_busy_run",          busy_4,      1);
        check("fwd4_in_ready_run",      in_ready_4,  0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("fwd4_out_valid_stall", out_valid_4, 1);
            check("fwd4_out_state_stall", out_state_4, EXP);
            check("fwd4_in_ready_stall",  in_ready_4,  0);
            if (k < 4) begin
                check("fwd1_out_valid_early", out_valid_1, 0);
                check("fwd1_busy_run",        busy_1,      1);
            end else if (k == 4) begin
                check("fwd1_out_valid_4cyc", out_valid_1, 1);
                check("fwd1_out_state",      out_state_1, EXP);
                check("fwd1_busy_done",      busy_1,      1);
            end else begin
                check("fwd1_back_idle_valid", out_valid_1, 0);
                check("fwd1_back_idle_ready", in_ready_1,  1);
            end
        end
        $display("txn forward: out4=%h out1=%h", out_state_4, out_state_1);
        out_ready_4 = 1'b1;
        step();
        check("fwd4_taken_valid",   out_valid_4, 0);
        check("fwd4_taken_ready",   in_ready_4,  1);
        check("fwd4_result_held",   out_state_4, EXP);

        // Inverse request (forward result when inverse support is absent)
        in_state = EXP; in_inverse = 1'b1;
        in_valid_4 = 1'b1; in_valid_1 = 1'b1;
        step();
        in_valid_4 = 1'b0; in_valid_1 = 1'b0;
        in_state = '0; in_inverse = 1'b0;
        step();
        check("inv4_out_valid", out_valid_4, 1);
        check("inv4_out_state", out_state_4, INV_EXP);
        step(); step(); step();
        check("inv1_out_valid", out_valid_1, 1);
        check("inv1_out_state", out_state_1, INV_EXP);
        $display("txn inverse: out4=%h out1=%h", out_state_4, out_state_1);
        step();

        // Flush in the second RUN cycle of the 1-lane engine
        in_state = VEC; in_valid_1 = 1'b1;
        step();
        in_valid_1 = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy",      busy_1,      0);
        check("flush_out_valid", out_valid_1, 0);
        check("flush_in_ready",  in_ready_1,  1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("flush_no_out_valid", out_valid_1, 0);
        end
        check("flush_keeps_last", out_state_1, INV_EXP);
        $display("txn flush: busy1=%0b out_valid1=%0b", busy_1, out_valid_1);

        // Next block after flush
        in_state = D4_VEC; in_valid_1 = 1'b1;
        step();
        in_valid_1 = 1'b0;
        step(); step(); step();
        check("d4_out_valid_early", out_valid_1, 0);
        step();
        check("d4_out_valid", out_valid_1, 1);
        check("d4_out_state", out_state_1, D4_EXP);
        $display("txn post-flush block: out1=%h", out_state_1);
        step();

        // Asynchronous reset mid-RUN
        in_state = VEC; in_valid_1 = 1'b1;
        step();
        in_valid_1 = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",       busy_1,      0);
        check("arst_out_valid",  out_valid_1, 0);
        check("arst_in_ready",   in_ready_1,  0);
        check("arst_out_state1", out_state_1, 0);
        check("arst_out_state4", out_state_4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_rel_no_edge", in_ready_1, 0);
        step();
        check("arst_rel_in_ready", in_ready_1, 1);
        check("arst_rel_busy",     busy_1,     0);
        $display("txn async reset: in_ready1=%0b busy1=%0b", in_ready_1, busy_1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
